// File: rtl/wb_arb2_if.sv
// wb_arb2_if: Wishbone classic bus bundle; master modport drives the request, slave modport answers it
interface wb_arb2_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  localparam int SW = DW / 8;
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [SW-1:0] sel;
  logic          ack;
  logic          err;
  logic [DW-1:0] dat_r;
  modport master (output cyc, stb, we, adr, dat_w, sel, input ack, err, dat_r);
  modport slave (input cyc, stb, we, adr, dat_w, sel, output ack, err, dat_r);
endinterface

// File: rtl/wb_arb2.sv
// wb_arb2: two-master round-robin Wishbone classic arbiter; watchdog/ERR/DRAIN built only with WB_ARB2_TIMEOUT_EN
module wb_arb2 #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input logic      clk_i,
  input logic      rst_ni,
  wb_arb2_if.slave  m0,
  wb_arb2_if.slave  m1,
  wb_arb2_if.master s
);
`ifdef WB_ARB2_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, GNT0, GNT1, ERR, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
`endif
  state_t state, state_n;
  logic last, last_n, gnt, own_cyc, own_stb, in_err;
  assign gnt = (state == GNT0) || (state == GNT1);
  assign own_cyc = last ? m1.cyc : m0.cyc;
  assign own_stb = last ? m1.stb : m0.stb;
`ifdef WB_ARB2_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wdt;
  logic expired;
  assign expired = own_stb && !s.ack && (wdt == WW'(TIMEOUT));
  assign in_err = state == ERR;
  // stall counter: runs only while the owner's strobe waits on the slave
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) wdt <= '0;
    else wdt <= (gnt && own_stb && !s.ack) ? wdt + 1'b1 : '0;
`else
  assign in_err = 1'b0;
`endif
  // state and last-granted register; reset favours master 0 on the first tie
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      last <= 1'b1;
    end else begin
      state <= state_n;
      last <= last_n;
    end
  // grant from IDLE only, so every ownership change crosses an IDLE cycle
  always_comb begin
    state_n = state;
    last_n = last;
    if (state == IDLE) begin
      if (m0.cyc && (!m1.cyc || last)) begin
        state_n = GNT0;
        last_n = 1'b0;
      end else if (m1.cyc) begin
        state_n = GNT1;
        last_n = 1'b1;
      end
    end else if (gnt) begin
      if (!own_cyc) state_n = IDLE;
`ifdef WB_ARB2_TIMEOUT_EN
      else if (expired) state_n = ERR;
    end else if (state == ERR) begin
      state_n = DRAIN;
    end else if (!own_cyc) begin
      state_n = IDLE;
`endif
    end
  end
  assign s.cyc = (gnt && own_cyc) || in_err;
  assign s.stb = gnt && own_stb;
  assign s.we = gnt && (last ? m1.we : m0.we);
  assign s.adr = gnt ? (last ? m1.adr : m0.adr) : '0;
  assign s.dat_w = gnt ? (last ? m1.dat_w : m0.dat_w) : '0;
  assign s.sel = gnt ? (last ? m1.sel : m0.sel) : '0;
  assign m0.ack = (state == GNT0) && s.ack && m0.cyc && m0.stb;
  assign m1.ack = (state == GNT1) && s.ack && m1.cyc && m1.stb;
  assign m0.err = in_err && !last;
  assign m1.err = in_err && last;
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: randomized scoreboard bench for wb_arb2 with a wb_mem-like slave model
module tb_wb_arb2;
  typedef struct {
    bit          err;
    bit          chk;
    logic [31:0] d;
  } ent_t;
  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic stall = 1'b0;
  logic force_ack = 1'b0;
  int tests = 0;
  int fails = 0;
  int cnt = 0;
  ent_t q0[$];
  ent_t q1[$];
  int seq_q[$];
  int t_q[$];
  logic [31:0] mem_m [1024];
  logic [31:0] smem [1024];
  logic ack_r;
  logic [31:0] rd;
  wb_arb2_if #(.AW(10), .DW(32)) m0_if ();
  wb_arb2_if #(.AW(10), .DW(32)) m1_if ();
  wb_arb2_if #(.AW(10), .DW(32)) s_if ();
  wb_arb2 #(.AW(10), .DW(32), .TIMEOUT(8)) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .m0(m0_if),
    .m1(m1_if),
    .s(s_if)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cnt++;
  // wb_mem-like slave: registered ack, low for a cycle after each ack
  always @(posedge clk or negedge rst_ni)
    if (!rst_ni) ack_r <= 1'b0;
    else if (s_if.cyc && s_if.stb && !ack_r && !stall) begin
      ack_r <= 1'b1;
      if (s_if.we) begin
        for (int b = 0; b < 4; b++) if (s_if.sel[b]) smem[s_if.adr][8*b +: 8] <= s_if.dat_w[8*b +: 8];
      end else rd <= smem[s_if.adr];
    end else ack_r <= 1'b0;
  assign s_if.ack = ack_r || force_ack;
  assign s_if.dat_r = rd;
  assign s_if.err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic score(input int m, input bit er, input logic [31:0] d);
    ent_t e;
    int sm;
    t_q.push_back(cnt);
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      tests++;
      fails++;
      $display("FAIL unexpected_resp: master %0d answered with nothing outstanding", m);
      return;
    end
    if (m == 0) e = q0.pop_front();
    else e = q1.pop_front();
    check("resp_kind", 32'(er), 32'(e.err));
    if (e.chk) check("rd_data", d, e.d);
    if (seq_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL grant_order: master %0d answered, no grant expected", m);
    end else begin
      sm = seq_q.pop_front();
      check("grant_order", 32'(m), 32'(sm));
    end
  endtask

  // monitor: pops the scoreboard whenever a master sees ack or err
  always @(negedge clk)
    if (rst_ni === 1'b1) begin
      if ((m0_if.ack || m0_if.err) && (m1_if.ack || m1_if.err)) begin
        fails++;
        $display("FAIL dual_resp: both masters answered in cycle %0d", cnt);
      end
      if ((m0_if.ack && m0_if.err) || (m1_if.ack && m1_if.err)) begin
        fails++;
        $display("FAIL ack_and_err: ack and err together in cycle %0d", cnt);
      end
      if (m0_if.ack || m0_if.err) score(0, m0_if.err, m0_if.dat_r);
      if (m1_if.ack || m1_if.err) score(1, m1_if.err, m1_if.dat_r);
    end

  task automatic drive(input int m, input bit c, input bit st, input bit w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] se);
    if (m == 0) begin
      m0_if.cyc = c; m0_if.stb = st; m0_if.we = w; m0_if.adr = a; m0_if.dat_w = d; m0_if.sel = se;
    end else begin
      m1_if.cyc = c; m1_if.stb = st; m1_if.we = w; m1_if.adr = a; m1_if.dat_w = d; m1_if.sel = se;
    end
  endtask

  function automatic bit got(input int m);
    return (m == 0) ? (m0_if.ack || m0_if.err) : (m1_if.ack || m1_if.err);
  endfunction

  // one bus cycle of n beats at consecutive addresses; lat = negedges until first ack
  task automatic run(input int m, input int n, input bit w, input logic [9:0] a0, input logic [31:0] d0, input logic [3:0] se, input bit seq, output int lat);
    ent_t e;
    int k;
    logic [9:0] a;
    logic [31:0] d;
    lat = 0;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      a = a0 + 10'(i);
      d = d0 + 32'(i);
      e.err = 1'b0;
      e.chk = !w;
      e.d = mem_m[a];
      if (w) for (int b = 0; b < 4; b++) if (se[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
      if (m == 0) q0.push_back(e);
      else q1.push_back(e);
      if (seq) seq_q.push_back(m);
      drive(m, 1, 1, w, a, d, se);
      k = 0;
      do begin @(negedge clk); k++; end while (!got(m) && k < 40);
      if (!got(m)) check("ack_wait", 0, 1);
      if (i == 0) lat = k;
      @(posedge clk); #1;
    end
    drive(m, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("rst_cyc", s_if.cyc, 0);
    check("rst_stb", s_if.stb, 0);
    check("rst_resp", {m0_if.ack, m1_if.ack, m0_if.err, m1_if.err}, 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic tie_test();
    int l0, l1, k;
    t_q.delete();
    seq_q.push_back(0);
    seq_q.push_back(1);
    fork
      run(0, 1, 0, 10'h010, 0, 4'hF, 0, l0);
      run(1, 1, 0, 10'h010, 0, 4'hF, 0, l1);
      begin
        k = 0;
        do begin @(negedge clk); k++; end while (!m0_if.ack && k < 40);
        @(negedge clk); check("gap_drop", s_if.stb, 0);
        @(negedge clk); check("gap_idle", s_if.stb, 0);
        @(negedge clk); check("gap_next", s_if.stb, 1);
      end
    join
    check("tie_lat", l0, 3);
    if (t_q.size() == 2) check("tie_gap", t_q[1] - t_q[0], 4);
    else check("tie_acks", t_q.size(), 2);
  endtask

  initial begin
    int lat, l0, l1, k, m;
    logic [9:0] a;
    logic [31:0] d;
    logic [3:0] se;
    drive(0, 0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, 0, '0, '0, '0);
    reset_dut();
    run(0, 1, 1, 10'h010, 32'hDEADBEEF, 4'hF, 1, lat);
    check("wr_lat", lat, 3);
    run(0, 1, 0, 10'h010, 0, 4'hF, 1, lat);
    check("rd_lat", lat, 3);
    for (int i = 0; i < 6; i++) begin
      m = int'($urandom_range(0, 1));
      a = 10'($urandom_range(32, 255));
      d = $urandom;
      se = 4'($urandom_range(1, 15));
      run(m, 1, 1, a, d, 4'hF, 1, lat);
      check("rnd_wr_lat", lat, 3);
      run(m, 1, 1, a, $urandom, se, 1, lat);
      run(1 - m, 1, 0, a, 0, 4'hF, 1, lat);
      check("rnd_rd_lat", lat, 3);
    end
    reset_dut();
    tie_test();
    reset_dut();
    for (int i = 0; i < 8; i++) seq_q.push_back(i % 2);
    fork
      for (int i = 0; i < 4; i++) run(0, 1, 1, 10'h100 + 10'(i), $urandom, 4'hF, 0, l0);
      for (int j = 0; j < 4; j++) run(1, 1, 0, 10'h010, 0, 4'hF, 0, l1);
    join
    t_q.delete();
    for (int i = 0; i < 4; i++) seq_q.push_back(0);
    seq_q.push_back(1);
    fork
      run(0, 4, 1, 10'h200, $urandom, 4'hF, 0, l0);
      begin @(posedge clk); run(1, 1, 0, 10'h010, 0, 4'hF, 0, l1); end
    join
    if (t_q.size() == 5) begin
      check("burst_beat", t_q[1] - t_q[0], 2);
      check("release_gap", t_q[4] - t_q[3], 4);
    end else check("burst_acks", t_q.size(), 5);
    @(posedge clk); #1;
    drive(1, 1, 1, 0, 10'h015, 0, 4'hF);
    k = 0;
    do begin @(negedge clk); k++; end while (!s_if.stb && k < 20);
    check("gnt1_adr", s_if.adr, 10'h015);
    #2 rst_ni = 1'b0;
    #1;
    check("async_cyc", s_if.cyc, 0);
    check("async_stb", s_if.stb, 0);
    drive(1, 0, 0, 0, '0, '0, '0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    tie_test();
`ifdef WB_ARB2_TIMEOUT_EN
    begin
      ent_t e;
      stall = 1'b1;
      e.err = 1'b1;
      e.chk = 1'b0;
      e.d = '0;
      q0.push_back(e);
      seq_q.push_back(0);
      @(posedge clk); #1;
      drive(0, 1, 1, 1, 10'h030, 32'h1234, 4'hF);
      k = 0;
      do begin @(negedge clk); k++; end while (!m0_if.err && k < 40);
      check("err_time", k, 11);
      check("err_bus", {s_if.cyc, s_if.stb}, 2'b10);
      @(negedge clk);
      check("err_once", m0_if.err, 0);
      force_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("drain_ack", m0_if.ack, 0);
        check("drain_cyc", s_if.cyc, 0);
      end
      @(posedge clk); #1;
      drive(0, 0, 0, 0, '0, '0, '0);
      force_ack = 1'b0;
      stall = 1'b0;
      run(0, 1, 0, 10'h010, 0, 4'hF, 1, lat);
      check("post_err_lat", lat, 3);
    end
`endif
    repeat (3) @(negedge clk);
    check("leftover", q0.size() + q1.size() + seq_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end
endmodule
